// File: rtl/count_mod_ud.sv
// count_mod_ud: modulo-N up/down counter with optional saturation, terminal count, carry pulse and sticky overflow.
// Ports:
//   Clk      - sole clock, rising edge
//   reset_n  - asynchronous active-low reset
//   En       - count enable, one step per clock
//   UpOrDown - direction, 1 = up, 0 = down
//   Clear    - synchronous clear to 0 (highest priority)
//   Load     - synchronous load of LoadVal (clamped to MODULUS-1)
//   LoadVal  - value written on Load
//   Count    - registered counter value, always < MODULUS
//   Tc       - combinational terminal count for the current direction
//   Carry    - registered one-cycle pulse per limit event
//   Ovf      - registered sticky limit-event flag, cleared only by Clear or reset
module count_mod_ud #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter bit SATURATE = 1'b0
) (
  input  logic             Clk,
  input  logic             reset_n,
  input  logic             En,
  input  logic             UpOrDown,
  input  logic             Clear,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadVal,
  output logic [WIDTH-1:0] Count,
  output logic             Tc,
  output logic             Carry,
  output logic             Ovf
);
  // Limit and comparisons are held one bit wider so MODULUS = 2^WIDTH needs no special case.
  localparam int MAX_I = MODULUS - 1;
  localparam logic [WIDTH:0] MAX = MAX_I[WIDTH:0];
  localparam logic [WIDTH-1:0] MAX_W = MAX_I[WIDTH-1:0];
  logic [WIDTH-1:0] count_q, count_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH:0]   cnt_x, ld_x;
  assign cnt_x = {1'b0, count_q};
  assign ld_x  = {1'b0, LoadVal};
  assign Tc    = UpOrDown ? (cnt_x == MAX) : (cnt_x == '0);
  // A plain step only happens away from the limit, so it can never leave 0..MODULUS-1.
  always_comb begin
    count_d = count_q;
    carry_d = 1'b0;
    ovf_d   = ovf_q;
    if (Clear) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (Load) begin
      count_d = (ld_x > MAX) ? MAX_W : LoadVal;
    end else if (En && Tc) begin
      carry_d = 1'b1;
      ovf_d   = 1'b1;
      count_d = SATURATE ? count_q : (UpOrDown ? '0 : MAX_W);
    end else if (En) begin
      count_d = UpOrDown ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
    end
  end
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end
  assign Count = count_q;
  assign Carry = carry_q;
  assign Ovf   = ovf_q;
endmodule

// File: tb/tb_count_mod_ud.sv
// tb_count_mod_ud: directed table and sequence checks of count_mod_ud in wrap and saturate configurations.
module tb_count_mod_ud;
  logic       Clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       En = 1'b0, UpOrDown = 1'b0, Clear = 1'b0, Load = 1'b0;
  logic [3:0] LoadVal = '0;
  logic [3:0] w_count, s_count;
  logic       w_tc, w_carry, w_ovf, s_tc, s_carry, s_ovf;
  int         n_cmp = 0;
  int         n_bad = 0;

  typedef struct {
    logic clr, ld, en, up;
    logic [3:0] lv;
    logic [3:0] cnt;
    logic ca, ov, tc;
  } vec_t;
  vec_t vecs[$];

  count_mod_ud #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_wrap (
    .Clk(Clk), .reset_n(reset_n), .En(En), .UpOrDown(UpOrDown), .Clear(Clear),
    .Load(Load), .LoadVal(LoadVal), .Count(w_count), .Tc(w_tc), .Carry(w_carry), .Ovf(w_ovf)
  );
  count_mod_ud #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) u_sat (
    .Clk(Clk), .reset_n(reset_n), .En(En), .UpOrDown(UpOrDown), .Clear(Clear),
    .Load(Load), .LoadVal(LoadVal), .Count(s_count), .Tc(s_tc), .Carry(s_carry), .Ovf(s_ovf)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic clr, input logic ld, input logic en, input logic up, input logic [3:0] lv);
    Clear = clr; Load = ld; En = en; UpOrDown = up; LoadVal = lv;
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_w(input string tag, input int c, input int ca, input int ov);
    chk({tag, " wrap count"}, int'(w_count), c);
    chk({tag, " wrap carry"}, int'(w_carry), ca);
    chk({tag, " wrap ovf"}, int'(w_ovf), ov);
  endtask

  task automatic chk_s(input string tag, input int c, input int ca, input int ov);
    chk({tag, " sat count"}, int'(s_count), c);
    chk({tag, " sat carry"}, int'(s_carry), ca);
    chk({tag, " sat ovf"}, int'(s_ovf), ov);
  endtask

  initial begin
    // Wrap config, MODULUS=10: {clr, ld, en, up, lv, count, carry, ovf, tc}
    for (int i = 1; i <= 9; i++) vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'(i), 1'b0, 1'b0, (i == 9)});
    vecs.push_back('{0, 0, 1, 1, 4'd0,  4'd0, 1, 1, 0});
    vecs.push_back('{0, 0, 1, 1, 4'd0,  4'd1, 0, 1, 0});
    vecs.push_back('{0, 0, 1, 1, 4'd0,  4'd2, 0, 1, 0});
    vecs.push_back('{1, 0, 1, 0, 4'd0,  4'd0, 0, 0, 1});
    vecs.push_back('{0, 0, 1, 0, 4'd0,  4'd9, 1, 1, 0});
    vecs.push_back('{0, 0, 1, 0, 4'd0,  4'd8, 0, 1, 0});
    vecs.push_back('{0, 0, 1, 0, 4'd0,  4'd7, 0, 1, 0});
    vecs.push_back('{0, 1, 1, 1, 4'd13, 4'd9, 0, 1, 1});
    vecs.push_back('{1, 1, 0, 1, 4'd5,  4'd0, 0, 0, 0});
    vecs.push_back('{0, 1, 1, 1, 4'd7,  4'd7, 0, 0, 0});
    vecs.push_back('{0, 1, 0, 1, 4'd9,  4'd9, 0, 0, 1});
    vecs.push_back('{0, 0, 0, 0, 4'd0,  4'd9, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 1, 4'd0,  4'd9, 0, 0, 1});
    vecs.push_back('{0, 0, 0, 0, 4'd0,  4'd9, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 1, 4'd0,  4'd9, 0, 0, 1});
    vecs.push_back('{0, 0, 0, 0, 4'd0,  4'd9, 0, 0, 0});
    vecs.push_back('{0, 0, 1, 1, 4'd0,  4'd0, 1, 1, 0});
    vecs.push_back('{0, 0, 0, 1, 4'd0,  4'd0, 0, 1, 0});
    vecs.push_back('{0, 0, 1, 0, 4'd0,  4'd9, 1, 1, 0});

    // Reset state, with inputs active to show they are ignored.
    drive(1'b0, 1'b1, 1'b1, 1'b1, 4'd5);
    step(); step();
    chk_w("reset", 0, 0, 0);
    chk_s("reset", 0, 0, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].clr, vecs[i].ld, vecs[i].en, vecs[i].up, vecs[i].lv);
      step();
      chk($sformatf("vec%0d count", i), int'(w_count), int'(vecs[i].cnt));
      chk($sformatf("vec%0d carry", i), int'(w_carry), int'(vecs[i].ca));
      chk($sformatf("vec%0d ovf", i), int'(w_ovf), int'(vecs[i].ov));
      chk($sformatf("vec%0d tc", i), int'(w_tc), int'(vecs[i].tc));
    end

    // Saturation: load 8, then up 4 edges holds at 9 with carry on each held edge.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 4'd0); step();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 4'd8); step();
    chk_s("satload", 8, 0, 0);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
    step(); chk_s("sat e1", 9, 0, 0);
    step(); chk_s("sat e2", 9, 1, 1);
    step(); chk_s("sat e3", 9, 1, 1);
    step(); chk_s("sat e4", 9, 1, 1);
    chk("sat tc", int'(s_tc), 1);

    // Reset during a carry pulse clears everything before the next edge.
    reset_n = 1'b0;
    #2;
    chk_s("rst pulse", 0, 0, 0);
    chk_w("rst pulse", 0, 0, 0);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 4'd5);
    step();
    chk_s("rst hold", 0, 0, 0);
    reset_n = 1'b1;

    // Down at 0: saturate holds, wrap goes to 9; consecutive saturated carries.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    step();
    chk_s("sat dn1", 0, 1, 1);
    chk_w("wrap dn1", 9, 1, 1);
    step();
    chk_s("sat dn2", 0, 1, 1);
    chk_w("wrap dn2", 8, 0, 1);

    // Reset pulsed between edges at Count=6, then counting resumes from 0.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 4'd0); step();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
    for (int i = 0; i < 6; i++) step();
    chk_w("pre rst", 6, 0, 0);
    reset_n = 1'b0;
    #2;
    chk_w("mid rst", 0, 0, 0);
    #1;
    reset_n = 1'b1;
    step(); chk_w("resume1", 1, 0, 0);
    step(); chk_w("resume2", 2, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
